// File: rtl/beat_timing_gen.sv
// -----------------------------------------------------------------------------
// beat_timing_gen
// Machine-cycle timing generator for the hardwired controller.
// A machine cycle is made of beats (w1..wN). Each beat is made of TSUB
// sub-phases (t[0]..t[TSUB-1]). The t3 strobe is one selected sub-phase and
// serves as the controller's state clock.
// The cycle length is chosen at each beat boundary from short/long:
//   short -> 1 beat, neither -> 2 beats, long -> NBEATS beats (short wins).
// At the end of a cycle, stop or step returns the block to IDLE. Otherwise the
// next cycle starts on the following clock with no gap.
//
// Ports
//   clk        in   master clock, all state on the rising edge
//   clr        in   asynchronous active-low reset
//   pulse      in   start request, honoured only in IDLE
//   step       in   single-step: halt after every cycle
//   stop       in   halt request, sampled on the end-of-cycle clock
//   short      in   end the cycle after w1 (wins over long)
//   long       in   run all NBEATS beats
//   w          out  one-hot beat, w[0] = w1, zero in IDLE
//   t          out  one-hot sub-phase within the beat, zero in IDLE
//   t3         out  t[T3_IDX]
//   beat_idx   out  current beat number
//   cycle_done out  high during the last sub-phase of a cycle
//   running    out  high in RUN
// -----------------------------------------------------------------------------
module beat_timing_gen #(
  parameter int NBEATS = 3,
  parameter int TSUB   = 4,
  parameter int T3_IDX = 2
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      pulse,
  input  logic                      step,
  input  logic                      stop,
  input  logic                      short,
  input  logic                      long,
  output logic [NBEATS-1:0]         w,
  output logic [TSUB-1:0]           t,
  output logic                      t3,
  output logic [$clog2(NBEATS)-1:0] beat_idx,
  output logic                      cycle_done,
  output logic                      running
);

  localparam int BW = $clog2(NBEATS);
  localparam int SW = $clog2(TSUB);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [SW-1:0] LAST_SUB  = SW'(TSUB - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_beat;
  logic [SW-1:0] r_sub;

  logic          w_last_sub;
  logic          w_end_cycle;

  // End-of-beat and end-of-cycle decode; short/long only matter on the last sub-phase
  always_comb begin
    w_last_sub  = 1'b0;
    w_end_cycle = 1'b0;
    if (r_state == RUN) begin
      w_last_sub  = (r_sub == LAST_SUB);
      w_end_cycle = w_last_sub &
                    (short | (~long & (r_beat != {BW{1'b0}})) | (r_beat == LAST_BEAT));
    end else begin
      w_last_sub  = 1'b0;
      w_end_cycle = 1'b0;
    end
  end

  // Sequencer: IDLE/RUN state with beat and sub-phase counters
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_beat  <= {BW{1'b0}};
      r_sub   <= {SW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          // Counters already sit at zero here, so starting only changes state
          if (pulse) begin
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
          r_beat <= {BW{1'b0}};
          r_sub  <= {SW{1'b0}};
        end
        RUN: begin
          if (!w_last_sub) begin
            r_sub <= r_sub + SW'(1);
          end else if (!w_end_cycle) begin
            r_beat <= r_beat + BW'(1);
            r_sub  <= {SW{1'b0}};
          end else begin
            // Cycle boundary: either halt or roll straight into the next cycle
            if (stop | step) begin
              r_state <= IDLE;
            end else begin
              r_state <= RUN;
            end
            r_beat <= {BW{1'b0}};
            r_sub  <= {SW{1'b0}};
          end
        end
        default: begin
          r_state <= IDLE;
          r_beat  <= {BW{1'b0}};
          r_sub   <= {SW{1'b0}};
        end
      endcase
    end
  end

  // One-hot output decode of the registered counters, all zero in IDLE
  always_comb begin
    w        = {NBEATS{1'b0}};
    t        = {TSUB{1'b0}};
    running  = 1'b0;
    if (r_state == RUN) begin
      w       = NBEATS'(1) << r_beat;
      t       = TSUB'(1) << r_sub;
      running = 1'b1;
    end else begin
      w       = {NBEATS{1'b0}};
      t       = {TSUB{1'b0}};
      running = 1'b0;
    end
  end

  assign t3         = t[T3_IDX];
  assign beat_idx   = r_beat;
  assign cycle_done = w_end_cycle;

endmodule

// File: tb/tb_beat_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_beat_timing_gen
// Scoreboard bench for beat_timing_gen (NBEATS=3, TSUB=4, T3_IDX=2).
// The driver applies inputs on the falling edge. A reference model tracks
// the clocks elapsed in the current machine cycle and the cycle length in
// beats. It pushes the expected outputs for that clock into a queue. The
// monitor pops one entry per clock and compares it with the DUT outputs,
// sampled between the falling and rising edges.
// -----------------------------------------------------------------------------
module tb_beat_timing_gen;

  localparam int NB = 3;
  localparam int TS = 4;
  localparam int T3 = 2;

  logic          clk;
  logic          clr;
  logic          pulse;
  logic          step;
  logic          stop;
  logic          short;
  logic          long;
  logic [NB-1:0] w;
  logic [TS-1:0] t;
  logic          t3;
  logic [1:0]    beat_idx;
  logic          cycle_done;
  logic          running;

  typedef struct packed {
    logic [NB-1:0] w;
    logic [TS-1:0] t;
    logic          t3;
    logic [1:0]    beat_idx;
    logic          cycle_done;
    logic          running;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int errors;
  int cyc;

  // Reference model state: in a cycle or not, clocks elapsed in the cycle
  bit m_run;
  int m_pos;

  beat_timing_gen #(.NBEATS(NB), .TSUB(TS), .T3_IDX(T3)) dut (
    .clk       (clk),
    .clr       (clr),
    .pulse     (pulse),
    .step      (step),
    .stop      (stop),
    .short     (short),
    .long      (long),
    .w         (w),
    .t         (t),
    .t3        (t3),
    .beat_idx  (beat_idx),
    .cycle_done(cycle_done),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock of inputs and push the expected outputs for that clock
  task automatic drive(input logic c, input logic p, input logic sp,
                       input logic so, input logic sh, input logic lo);
    exp_t e;
    int   beat;
    int   sub;
    int   target;
    @(negedge clk);
    clr = c; pulse = p; step = sp; stop = so; short = sh; long = lo;
    e = '0;
    if (!c) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (m_run) begin
      beat = m_pos / TS;
      sub  = m_pos % TS;
      e.w        = NB'(1) << beat;
      e.t        = TS'(1) << sub;
      e.t3       = (sub == T3);
      e.beat_idx = 2'(beat);
      e.running  = 1'b1;
      // Cycle length in beats, as chosen at this clock's inputs
      target = sh ? 1 : (lo ? NB : 2);
      if ((sub == TS - 1) && (beat + 1 >= target)) begin
        e.cycle_done = 1'b1;
        m_pos = 0;
        if (so || sp) m_run = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else begin
      if (p) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per clock, sampled mid-way through the low phase
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {w, t, t3, beat_idx, cycle_done, running};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got w=%b t=%b t3=%b bi=%0d cd=%b run=%b want w=%b t=%b t3=%b bi=%0d cd=%b run=%b",
                   cyc, a.w, a.t, a.t3, a.beat_idx, a.cycle_done, a.running,
                   e.w, e.t, e.t3, e.beat_idx, e.cycle_done, e.running);
        end
        cyc++;
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_run = 1'b0; m_pos = 0;
    clr = 1'b0; pulse = 1'b1; step = 1'b0; stop = 1'b0; short = 1'b0; long = 1'b0;

    // Reset held with pulse high: everything stays zero
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Normal 2-beat cycles back to back
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Long cycles
    repeat (26) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Short, then short and long together
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Single step: halts at the cycle end, then idles
    repeat (12) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Restart under step; pulses during RUN are ignored
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Restart free-running; stop raised mid-cycle then dropped before the end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Stop held through a cycle end halts
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Restart, reach beat 1 sub 1, then pulse clr
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) != 0),
            ($urandom_range(3) == 0),
            ($urandom_range(7) == 0),
            ($urandom_range(5) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(2) == 0));
    end

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
